// File: rtl/ising_axi_read.sv
// Single-outstanding AXI-lite read responder for the Ising machine: STATUS, sampler config, ID and spin phases.
// Optional `ISING_RD_SNAPSHOT_EN: a read of PHASE word 0 freezes a copy of phase, which later PHASE words return.
module ising_axi_read #(
  parameter int unsigned N            = 3,
  parameter int unsigned SAMPLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    axi_rstn,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [31:0]             araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  input  logic [N-1:0]            phase,
  input  logic                    sample_valid,
  input  logic [31:0]             counter_max,
  input  logic [31:0]             counter_cutoff
);

  localparam int unsigned W        = (N + 31) / 32;
  localparam int unsigned PW       = 32 * W;
  localparam logic [31:0] ID_WORD  = {16'h15E9, 16'(N)};
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_ERR = 2'b10;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    arready_d, rvalid_d;
  logic [31:0]             rdata_d;
  logic [1:0]              rresp_d;
  logic [SAMPLE_CNT_W-1:0] sample_cnt;
  logic [29:0]             word_addr;
  logic [PW-1:0]           phase_src;
  logic [31:0]             status_word;
  logic                    unused_addr_bits;

  assign word_addr        = araddr[31:2];
  assign unused_addr_bits = ^araddr[1:0];

`ifdef ISING_RD_SNAPSHOT_EN
  logic [N-1:0] snap_q;
  logic         snap_cap_c;

  assign snap_cap_c  = (state_q == S_IDLE) && arvalid && arready && (word_addr == 30'd4);
  assign status_word = {1'b1, 31'(sample_cnt)};

  // Word 0 is live (it is the capture itself); higher words come from the frozen copy.
  always_comb begin
    phase_src = (PW'(snap_q) & ~PW'(32'hFFFF_FFFF)) | (PW'(phase) & PW'(32'hFFFF_FFFF));
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      snap_q <= '0;
    end else if (snap_cap_c) begin
      snap_q <= phase;
    end
  end
`else
  assign status_word = 32'(sample_cnt);
  assign phase_src   = PW'(phase);
`endif

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      sample_cnt <= '0;
    end else if (sample_valid) begin
      sample_cnt <= sample_cnt + SAMPLE_CNT_W'(1);
    end
  end

  // Next-state, address decode and registered response.
  always_comb begin
    state_d   = state_q;
    arready_d = arready;
    rvalid_d  = rvalid;
    rdata_d   = rdata;
    rresp_d   = rresp;
    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready) begin
          state_d   = S_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          rresp_d   = RESP_ERR;
          case (word_addr)
            30'd0: begin rdata_d = status_word;    rresp_d = RESP_OK; end
            30'd1: begin rdata_d = counter_max;    rresp_d = RESP_OK; end
            30'd2: begin rdata_d = counter_cutoff; rresp_d = RESP_OK; end
            30'd3: begin rdata_d = ID_WORD;        rresp_d = RESP_OK; end
            default: ;
          endcase
          for (int unsigned k = 0; k < W; k++) begin
            if (word_addr == 30'(4 + k)) begin
              rdata_d = phase_src[32*k +: 32];
              rresp_d = RESP_OK;
            end
          end
        end
      end
      S_RESP: begin
        arready_d = 1'b0;
        if (rready) begin
          state_d   = S_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= S_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      state_q <= state_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
    end
  end

endmodule
